// File: rtl/axi_slave_read_ctrl_if.sv
// AR/R channel bundle between the read-data interconnect (master side) and
// the slave read responder (slave side).
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

interface axi_slave_read_ctrl_if;
  logic [`AXI_IDS_BITS-1:0]  ARID;
  logic [`AXI_ADDR_BITS-1:0] ARADDR;
  logic [`AXI_LEN_BITS-1:0]  ARLEN;
  logic [`AXI_SIZE_BITS-1:0] ARSIZE;
  logic [1:0]                ARBURST;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [`AXI_IDS_BITS-1:0]  RID;
  logic [`AXI_DATA_BITS-1:0] RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_slave_read_ctrl.sv
// AXI slave read responder: one AR burst at a time, word reads from a
// synchronous SRAM. Optional macro AXI_RD_PREFETCH_EN overlaps the next read.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_slave_read_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  axi_slave_read_ctrl_if.slave axi,
  output logic                SRAM_CEB,
  output logic [ADDR_W-1:0]   SRAM_A,
  input  logic [31:0]         SRAM_DO
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;

  logic [1:0]                state_r;
  logic [1:0]                state_next_s;
  logic [`AXI_IDS_BITS-1:0]  id_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [`AXI_LEN_BITS-1:0]  len_r;
  logic [`AXI_LEN_BITS-1:0]  beat_r;
  logic                      fixed_r;
  logic                      first_r;
  logic [31:0]               hold_r;
  logic [ADDR_W-1:0]         sram_a_r;
  logic                      issue_s;
  logic [ADDR_W-1:0]         issue_addr_s;
  logic [ADDR_W-1:0]         addr_step_s;
  logic                      ar_hs_s;
  logic                      r_hs_s;
  logic                      last_s;
  logic                      unused_s;

  assign ar_hs_s     = (state_r == IDLE) && axi.ARVALID;
  assign r_hs_s      = (state_r == RD_DATA) && axi.RREADY;
  assign last_s      = (beat_r == len_r);
  assign addr_step_s = fixed_r ? addr_r : (addr_r + ADDR_W'(1));
  assign unused_s    = ^{axi.ARSIZE, axi.ARADDR[`AXI_ADDR_BITS-1:ADDR_W+2], axi.ARADDR[1:0]};

  // Next-state decode and SRAM read issue
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = addr_r;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) state_next_s = RD_REQ;
        else         state_next_s = IDLE;
      end
      RD_REQ: begin
        issue_s      = 1'b1;
        issue_addr_s = addr_r;
        state_next_s = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs_s && last_s) begin
          state_next_s = IDLE;
        end else if (r_hs_s) begin
`ifdef AXI_RD_PREFETCH_EN
          issue_s      = 1'b1;
          issue_addr_s = addr_step_s;
          state_next_s = RD_DATA;
`else
          state_next_s = RD_REQ;
`endif
        end else begin
          state_next_s = RD_DATA;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next_s;
  end

  // Burst context: ID, address, length, beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      beat_r  <= '0;
      fixed_r <= 1'b0;
    end else if (ar_hs_s) begin
      id_r    <= axi.ARID;
      addr_r  <= axi.ARADDR[ADDR_W+1:2];
      len_r   <= axi.ARLEN;
      beat_r  <= '0;
      fixed_r <= (axi.ARBURST == 2'b00);
    end else if (r_hs_s && !last_s) begin
      beat_r  <= beat_r + `AXI_LEN_BITS'(1);
      addr_r  <= addr_step_s;
    end else begin
      beat_r  <= beat_r;
      addr_r  <= addr_r;
    end
  end

  // Data path: first RD_DATA cycle follows every issued read; the hold
  // register keeps RDATA stable once SRAM_DO moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_r  <= 1'b0;
      hold_r   <= 32'h0000_0000;
      sram_a_r <= '0;
    end else begin
      first_r  <= issue_s;
      hold_r   <= first_r ? SRAM_DO : hold_r;
      sram_a_r <= issue_s ? issue_addr_s : sram_a_r;
    end
  end

  assign SRAM_CEB   = ~issue_s;
  assign SRAM_A     = issue_s ? issue_addr_s : sram_a_r;

  assign axi.ARREADY = (state_r == IDLE);
  assign axi.RVALID  = (state_r == RD_DATA);
  assign axi.RLAST   = (state_r == RD_DATA) && last_s;
  assign axi.RID     = id_r;
  assign axi.RDATA   = first_r ? SRAM_DO : hold_r;
  assign axi.RRESP   = 2'b00;

endmodule

// File: tb/tb_axi_slave_read_ctrl.sv
// Scoreboard bench for axi_slave_read_ctrl: expected beats and SRAM addresses
// are queued by the stimulus and consumed by independent monitors.
module tb_axi_slave_read_ctrl;
  logic        clk;
  logic        rst;
  logic        sram_ceb;
  logic [13:0] sram_a;
  logic [31:0] sram_do;
  logic        garbage;
  int          n_checks;
  int          n_errors;

  typedef struct packed {
    logic [7:0]  id;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [13:0] exp_addr_q[$];

  axi_slave_read_ctrl_if bus();

  axi_slave_read_ctrl #(.ADDR_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .axi      (bus),
    .SRAM_CEB (sram_ceb),
    .SRAM_A   (sram_a),
    .SRAM_DO  (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [13:0] a);
    if (a == 14'd4) return 32'hDEAD_BEEF;
    return {16'hC0DE, 2'b00, a};
  endfunction

  // SRAM model: one-cycle read latency; garbage mode scrambles idle output
  always @(posedge clk) begin
    if (!sram_ceb)     sram_do <= memval(sram_a);
    else if (garbage)  sram_do <= 32'hBAD0_0000 ^ $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // R-channel monitor: compare every presented beat with the queue head
  always @(negedge clk) begin
    if (rst && bus.RVALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        check("rdata", {32'd0, bus.RDATA}, {32'd0, exp_q[0].data});
        check("rid",   {56'd0, bus.RID},   {56'd0, exp_q[0].id});
        check("rlast", {63'd0, bus.RLAST}, {63'd0, exp_q[0].last});
        check("rresp", {62'd0, bus.RRESP}, 64'd0);
        if (bus.RREADY) void'(exp_q.pop_front());
      end
    end
  end

  // SRAM monitor: every issued read must match the next expected address
  always @(negedge clk) begin
    if (rst && !sram_ceb) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_read", 64'd1, 64'd0);
      end else begin
        check("sram_a", {50'd0, sram_a}, {50'd0, exp_addr_q.pop_front()});
      end
    end
  end

  task automatic push_beat(input logic [13:0] a, input logic [7:0] id, input logic last);
    beat_t b;
    b.id = id; b.last = last; b.data = memval(a);
    exp_q.push_back(b);
    exp_addr_q.push_back(a);
  endtask

  // Present AR for one handshake cycle (cycle 0); returns early in cycle 1
  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    @(posedge clk); #1;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
    bus.ARSIZE = 3'b010; bus.ARBURST = burst; bus.ARVALID = 1'b1;
    @(negedge clk);
    check("arready_c0", {63'd0, bus.ARREADY}, 64'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.ARREADY && exp_q.size() == 0 && exp_addr_q.size() == 0) done = 1'b1;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [9:0] exp_rv;
    int         idle_c;
    n_checks = 0; n_errors = 0; garbage = 1'b0;
    bus.ARID = 8'd0; bus.ARADDR = 32'd0; bus.ARLEN = 4'd0; bus.ARSIZE = 3'd0;
    bus.ARBURST = 2'b01; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    rst = 1'b0;

    // Reset with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.ARVALID = 1'($urandom); bus.RREADY = 1'($urandom);
      @(negedge clk);
      check("rst_arready", {63'd0, bus.ARREADY}, 64'd1);
      check("rst_rvalid",  {63'd0, bus.RVALID},  64'd0);
      check("rst_ceb",     {63'd0, sram_ceb},    64'd1);
    end
    check("rst_rdata", {32'd0, bus.RDATA}, 64'd0);
    check("rst_sram_a", {50'd0, sram_a}, 64'd0);
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_arready", {63'd0, bus.ARREADY}, 64'd1);
      check("post_rst_rvalid",  {63'd0, bus.RVALID},  64'd0);
      check("post_rst_ceb",     {63'd0, sram_ceb},    64'd1);
    end

    // Single beat
    push_beat(14'h0004, 8'h15, 1'b1);
    send_ar(8'h15, 32'h0000_0010, 4'd0, 2'b01);
    @(negedge clk);
    check("single_c1_ceb", {63'd0, sram_ceb}, 64'd0);
    check("single_c1_a", {50'd0, sram_a}, 64'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_c2_rvalid", {63'd0, bus.RVALID}, 64'd1);
    check("single_c2_rdata", {32'd0, bus.RDATA}, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_c3_arready", {63'd0, bus.ARREADY}, 64'd1);
    wait_idle("single_done");

    // INCR wrap across the top of the word space
    push_beat(14'h3FFE, 8'h2A, 1'b0);
    push_beat(14'h3FFF, 8'h2A, 1'b0);
    push_beat(14'h0000, 8'h2A, 1'b0);
    push_beat(14'h0001, 8'h2A, 1'b1);
    send_ar(8'h2A, 32'h0000_FFF8, 4'd3, 2'b01);
    wait_idle("wrap_done");

    // Backpressure on beat 1 while SRAM output is scrambled
    garbage = 1'b1;
    bus.RREADY = 1'b0;
    push_beat(14'h0030, 8'h31, 1'b0);
    push_beat(14'h0031, 8'h31, 1'b1);
    send_ar(8'h31, 32'h0000_00C0, 4'd1, 2'b01);
    repeat (6) begin
      @(posedge clk); #1;
    end
    bus.RREADY = 1'b1;
    wait_idle("bp_done");
    garbage = 1'b0;

    // FIXED burst
    push_beat(14'h0008, 8'h07, 1'b0);
    push_beat(14'h0008, 8'h07, 1'b0);
    push_beat(14'h0008, 8'h07, 1'b1);
    send_ar(8'h07, 32'h0000_0020, 4'd2, 2'b00);
    wait_idle("fixed_done");

    // Beat timing with RREADY held high
`ifdef AXI_RD_PREFETCH_EN
    exp_rv = 10'h03C; idle_c = 6;
`else
    exp_rv = 10'h154; idle_c = 9;
`endif
    for (int i = 0; i < 4; i++) push_beat(14'h0040 + 14'(i), 8'h10, (i == 3));
    send_ar(8'h10, 32'h0000_0100, 4'd3, 2'b01);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("timing_rvalid", {63'd0, bus.RVALID}, {63'd0, exp_rv[c]});
      check("timing_arready", {63'd0, bus.ARREADY}, {63'd0, (c >= idle_c)});
      @(posedge clk); #1;
    end
    wait_idle("timing_done");

    // Reset during beat 2
    for (int i = 0; i < 4; i++) push_beat(14'h0080 + 14'(i), 8'h3C, (i == 3));
    send_ar(8'h3C, 32'h0000_0200, 4'd3, 2'b01);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.RVALID) seen = 1'b1;
      end
      check("mid_beat1_seen", {63'd0, seen}, 64'd1);
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.RVALID) seen = 1'b1;
      end
      check("mid_beat2_seen", {63'd0, seen}, 64'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rvalid", {63'd0, bus.RVALID}, 64'd0);
    check("mid_rst_ceb", {63'd0, sram_ceb}, 64'd1);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.RREADY = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_post_arready", {63'd0, bus.ARREADY}, 64'd1);
      check("mid_post_rvalid", {63'd0, bus.RVALID}, 64'd0);
    end

    check("exp_q_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("exp_addr_q_empty", {32'd0, 32'(exp_addr_q.size())}, 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
